palindrome_gen: RTL and testbench

Serial palindrome generator that drives a 1-bit serial stream for the team's serial palindrome detectors. It accepts a WIDTH-bit "half word" plus an odd/even mode over a valid/ready handshake. It then shifts out the half MSB-first, followed by its mirror, which forms a palindrome of 2*WIDTH-1 bits (odd) or 2*WIDTH bits (even). The serial side has its own valid/ready handshake so downstream can stall the stream.

---
 rtl/palindrome_gen.sv | 99 +++++++++
 tb/tb_palindrome_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/palindrome_gen.sv
// rtl/palindrome_gen.sv - serial palindrome generator: half word in, mirrored bit stream out
module palindrome_gen #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] half_i,
  input  logic             odd_i,
  output logic             x_o,
  output logic             x_valid_o,
  input  logic             x_ready_i,
  output logic             last_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] ONE      = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             odd_q, odd_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             accept;
  logic             xfer;

  // Output decode and handshake qualifiers, all straight from the registered state
  always_comb begin
    x_valid_o  = (state_q != IDLE);
    x_o        = x_valid_o ? hold_q[idx_q] : 1'b0;
    last_o     = (state_q == REV) && (idx_q == LAST_IDX);
    in_ready_o = (state_q == IDLE) || (last_o && x_ready_i);
    accept     = in_valid_i && in_ready_o;
    xfer       = x_valid_o && x_ready_i;
  end

  // Next-state: walk idx down through the half, then back up through the mirror
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    odd_d   = odd_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
      end
      FWD: begin
        if (xfer) begin
          if (idx_q == '0) begin
            state_d = REV;
            // odd mode skips the centre bit on the way back
            idx_d   = odd_q ? ONE : '0;
          end else begin
            idx_d = idx_q - ONE;
          end
        end
      end
      REV: begin
        if (xfer) begin
          if (last_o) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // accept is only possible in IDLE or on the final beat, so it overrides the above
    if (accept) begin
      hold_d  = half_i;
      odd_d   = odd_i;
      idx_d   = LAST_IDX;
      state_d = FWD;
    end
  end

  // State registers; reset abandons any palindrome in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      odd_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      odd_q   <= odd_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_palindrome_gen.sv
// tb/tb_palindrome_gen.sv - self-checking bench for palindrome_gen
module tb_palindrome_gen;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] half_i;
  logic         odd_i;
  logic         x_o;
  logic         x_valid_o;
  logic         x_ready_i;
  logic         last_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit exp_q[$];
  bit got_x[$];
  bit got_l[$];
  int got_c[$];
  bit m_busy;
  bit m_rdy;

  palindrome_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .half_i     (half_i),
    .odd_i      (odd_i),
    .x_o        (x_o),
    .x_valid_o  (x_valid_o),
    .x_ready_i  (x_ready_i),
    .last_o     (last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A palindrome is the half MSB-first followed by its mirror, minus the centre bit in odd mode
  task automatic model_push(logic [W-1:0] h, logic o);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(h[i]);
    for (int i = (o ? 1 : 0); i < W; i++) exp_q.push_back(h[i]);
  endtask

  // Compare every cycle at the falling edge, then advance the model past the coming rising edge
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_valid", x_valid_o, 0);
      chk("rst_x", x_o, 0);
      chk("rst_last", last_o, 0);
      chk("rst_ready", in_ready_o, 1);
      exp_q.delete();
    end else begin
      m_busy = (exp_q.size() != 0);
      m_rdy  = !m_busy || (exp_q.size() == 1 && x_ready_i);
      chk("valid", x_valid_o, m_busy);
      chk("ready", in_ready_o, m_rdy);
      chk("x", x_o, m_busy ? exp_q[0] : 1'b0);
      chk("last", last_o, m_busy && exp_q.size() == 1);
      if (m_busy && x_ready_i) begin
        got_x.push_back(x_o);
        got_l.push_back(last_o);
        got_c.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (in_valid_i && m_rdy) model_push(half_i, odd_i);
    end
  end

  task automatic send(logic [W-1:0] h, logic o);
    int n = 0;
    bit acc = 1'b0;
    in_valid_i = 1'b1;
    half_i     = h;
    odd_i      = o;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_x.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic check_seq(string nm, int n, logic [15:0] bits, logic [15:0] lasts, bit contig);
    chk({nm, "_len"}, got_x.size(), n);
    for (int i = 0; i < n && i < got_x.size(); i++) begin
      chk($sformatf("%s_bit%0d", nm, i), got_x[i], bits[n-1-i]);
      chk($sformatf("%s_last%0d", nm, i), got_l[i], lasts[n-1-i]);
    end
    if (contig && got_c.size() == n) chk({nm, "_contig"}, got_c[n-1] - got_c[0], n - 1);
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_valid_i = 1'b0;
    half_i     = '0;
    odd_i      = 1'b0;
    x_ready_i  = 1'b1;
    #2;
    chk("por_valid", x_valid_o, 0);
    chk("por_ready", in_ready_o, 1);
    chk("por_x", x_o, 0);
    chk("por_last", last_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_log();

    // odd 110 -> 11011
    send(3'b110, 1'b1);
    wait_idle();
    check_seq("odd110", 5, 16'b11011, 16'b00001, 1'b1);
    chk("odd110_idle_valid", x_valid_o, 0);
    chk("odd110_idle_ready", in_ready_o, 1);

    // even 100 -> 100001
    send(3'b100, 1'b0);
    wait_idle();
    check_seq("even100", 6, 16'b100001, 16'b000001, 1'b1);

    // stall three cycles on beat 2
    send(3'b110, 1'b1);
    @(posedge clk);
    #1;
    x_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_x", x_o, 1);
      chk("stall_valid", x_valid_o, 1);
      chk("stall_last", last_o, 0);
    end
    @(posedge clk);
    #1;
    x_ready_i = 1'b1;
    wait_idle();
    check_seq("stall", 5, 16'b11011, 16'b00001, 1'b0);

    // back-to-back: 101 odd then 011 even, no gap
    send(3'b101, 1'b1);
    send(3'b011, 1'b0);
    wait_idle();
    check_seq("b2b", 11, 16'b10101_011110, 16'b00001_000001, 1'b1);

    // reset during beat 3, then a fresh 010 odd
    send(3'b110, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", x_valid_o, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", x_valid_o, 0);
    chk("mid_rst_x", x_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_ready", in_ready_o, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    send(3'b010, 1'b1);
    wait_idle();
    check_seq("after_rst", 5, 16'b01010, 16'b00001, 1'b1);

    // inputs wiggle while busy and must be ignored
    send(3'b110, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid_i = (i != 1);
      half_i     = W'($urandom);
      odd_i      = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    wait_idle();
    check_seq("busy_ignore", 5, 16'b11011, 16'b00001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
